// File: rtl/hive_gpio_ctrl.sv
// hive_gpio_ctrl: rbus-mapped GPIO controller with atomic set/clear outputs,
// synchronised (optionally debounced) inputs, sticky W1C edge flags and a level irq.
//
// Optional feature macro: GPIO_DEBOUNCE_EN
//   defined   -> prescaler + 3-sample debounce on the input path, DIV register present
//   undefined -> IN is the 2-flop synchroniser output, DIV reads 0 and ignores writes
//
// Ports:
//   clk_i           clock
//   rst_n_i         asynchronous reset, active low
//   rbus_addr_i     register address (window BASE_ADDR..BASE_ADDR+7)
//   rbus_wr_i       write strobe
//   rbus_rd_i       read strobe
//   rbus_wr_data_i  write data
//   rbus_rd_data_o  registered read data, 0 when no read was addressed last cycle
//   gpio_i          asynchronous pad inputs
//   gpio_o          pad outputs (OUT register)
//   irq_o           registered OR of FLAGS
module hive_gpio_ctrl #(
    parameter int ALU_W       = 32,
    parameter int RBUS_ADDR_W = 8,
    parameter int BASE_ADDR   = 'h10,
    parameter int DIV_W       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [RBUS_ADDR_W-1:0] rbus_addr_i,
    input  logic                   rbus_wr_i,
    input  logic                   rbus_rd_i,
    input  logic [ALU_W-1:0]       rbus_wr_data_i,
    output logic [ALU_W-1:0]       rbus_rd_data_o,
    input  logic [ALU_W-1:0]       gpio_i,
    output logic [ALU_W-1:0]       gpio_o,
    output logic                   irq_o
);
    localparam logic [RBUS_ADDR_W-1:0] BASE = RBUS_ADDR_W'(BASE_ADDR);

    logic [RBUS_ADDR_W-1:0] off;
    logic                   hit;
    logic [2:0]             sel;
    logic                   we;
    logic                   re;

    assign off = rbus_addr_i - BASE;
    assign hit = (rbus_addr_i >= BASE) && (off < RBUS_ADDR_W'(8));
    assign sel = off[2:0];
    assign we  = rbus_wr_i && hit;
    assign re  = rbus_rd_i && hit;

    logic [ALU_W-1:0] out_q, out_d;
    logic [ALU_W-1:0] rise_en_q, rise_en_d;
    logic [ALU_W-1:0] fall_en_q, fall_en_d;
    logic [ALU_W-1:0] flags_q, flags_d;
    logic [ALU_W-1:0] rd_data_q, rd_data_d;
    logic [ALU_W-1:0] sync1_q, sync2_q;
    logic [ALU_W-1:0] in_prev_q;
    logic             irq_q, irq_d;
    logic [ALU_W-1:0] in_cur;
    logic [ALU_W-1:0] rise;
    logic [ALU_W-1:0] fall;
    logic [DIV_W-1:0] div_rd;

`ifdef GPIO_DEBOUNCE_EN
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [ALU_W-1:0] h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
    logic [ALU_W-1:0] deb_q, deb_d;
    logic             tick;

    always_comb begin
        tick  = cnt_q == '0;
        div_d = (we && sel == 3'd7) ? rbus_wr_data_i[DIV_W-1:0] : div_q;
        // a DIV write restarts the count from the new value
        cnt_d = (we && sel == 3'd7) ? rbus_wr_data_i[DIV_W-1:0] :
                tick ? div_q : cnt_q - DIV_W'(1);
        h0_d  = tick ? sync2_q : h0_q;
        h1_d  = tick ? h0_q : h1_q;
        h2_d  = tick ? h1_q : h2_q;
        // all-ones -> 1, all-zeros -> 0, disagreement -> hold
        deb_d = tick ? ((h0_d & h1_d & h2_d) | (deb_q & (h0_d | h1_d | h2_d))) : deb_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q <= '0;
            cnt_q <= '0;
            h0_q  <= '0;
            h1_q  <= '0;
            h2_q  <= '0;
            deb_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            h0_q  <= h0_d;
            h1_q  <= h1_d;
            h2_q  <= h2_d;
            deb_q <= deb_d;
        end
    end

    assign in_cur = deb_q;
    assign div_rd = div_q;
`else
    assign in_cur = sync2_q;
    assign div_rd = '0;
`endif

    always_comb begin
        out_d     = (we && sel == 3'd0) ? rbus_wr_data_i :
                    (we && sel == 3'd1) ? (out_q | rbus_wr_data_i) :
                    (we && sel == 3'd2) ? (out_q & ~rbus_wr_data_i) : out_q;
        rise_en_d = (we && sel == 3'd4) ? rbus_wr_data_i : rise_en_q;
        fall_en_d = (we && sel == 3'd5) ? rbus_wr_data_i : fall_en_q;
        rise      = in_cur & ~in_prev_q;
        fall      = ~in_cur & in_prev_q;
        // new captures are ORed after the clear so they win over a same-cycle W1C
        flags_d   = (flags_q & ~((we && sel == 3'd6) ? rbus_wr_data_i : '0)) |
                    (rise & rise_en_q) | (fall & fall_en_q);
        irq_d     = |flags_q;
        rd_data_d = !re ? '0 :
                    (sel == 3'd0) ? out_q :
                    (sel == 3'd3) ? in_cur :
                    (sel == 3'd4) ? rise_en_q :
                    (sel == 3'd5) ? fall_en_q :
                    (sel == 3'd6) ? flags_q :
                    (sel == 3'd7) ? ALU_W'(div_rd) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            flags_q   <= '0;
            rd_data_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            in_prev_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            flags_q   <= flags_d;
            rd_data_q <= rd_data_d;
            sync1_q   <= gpio_i;
            sync2_q   <= sync1_q;
            in_prev_q <= in_cur;
            irq_q     <= irq_d;
        end
    end

    assign gpio_o         = out_q;
    assign rbus_rd_data_o = rd_data_q;
    assign irq_o          = irq_q;
endmodule
